answer_entry: RTL and testbench
===============================

Name: answer_entry

Overview:
- Upstream neighbour of answer_check in the quiz game.
- Consumes decoded PS/2 set-2 scan-code bytes from the keyboard receiver.
- Assembles the player's typed decimal answer into kb_result.
- Emits a one-cycle submit pulse when Enter is pressed; answer_check uses it as its new_ques/check strobe.

Parameters:
- MAX_DIGITS, 2, maximum decimal digits accepted; 2 gives 0..99.
- RES_W, 7, width of kb_result; must hold 10^MAX_DIGITS-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- scan_code  in  8  byte from PS/2 receiver; valid only with scan_valid.
- scan_valid  in  1  one-cycle strobe, scan_code valid.
- clear  in  1  one-cycle strobe at new question; empties the entry buffer and unlocks it.
- kb_result  out  RES_W  current typed value, registered.
- digit_count  out  2  number of digits currently held.
- submit  out  1  one-cycle pulse, answer complete.
- locked  out  1  high after submit until clear; keystrokes ignored.

Behaviour:
- Reset (async, active-high): kb_result=0, digit_count=0, submit=0, locked=0, FSM=S_MAKE.
- Parser FSM advances only on scan_valid:
  - S_MAKE: byte F0 -> S_BREAK; E0 -> S_EXT; else process as a make code, stay.
  - S_BREAK: any byte is discarded -> S_MAKE.
  - S_EXT: F0 -> S_EXT_BREAK; 5A (keypad Enter) -> process as Enter, -> S_MAKE; else discard -> S_MAKE.
  - S_EXT_BREAK: discard -> S_MAKE.
- Make-code actions are taken only when locked=0. Parsing continues while locked, so the FSM stays aligned.
  - Digit keys. Main row: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9. Keypad: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
    - Digit with digit_count<MAX_DIGITS: kb_result=kb_result*10+d, digit_count+1.
    - Digit with digit_count=MAX_DIGITS: ignored; no wrap, no overwrite.
  - Backspace (66): if digit_count>0, kb_result=kb_result/10 and digit_count-1; at 0, ignored.
  - Enter (5A, or E0 5A): if digit_count>0, submit=1 for exactly one cycle and locked=1; kb_result holds. At digit_count=0, ignored (no empty answers).
  - Any other code: ignored.
- Latency:
  - A byte strobed in cycle N updates kb_result, digit_count, submit and locked at the edge ending N; they are visible in cycle N+1.
  - kb_result is final and stable in the same cycle submit is high.
- Leading zeros: "0","7" yields 7 with digit_count=2.
- Typematic repeats (repeated make codes) are treated as separate keystrokes.
- clear:
  - kb_result=0, digit_count=0, locked=0, FSM=S_MAKE, submit=0.
  - Clear and scan_valid in the same cycle: clear wins and the byte is dropped.
  - Clear in the same cycle that Enter would submit: no submit.
- Arithmetic:
  - Multiply-by-10 is done as (x<<3)+(x<<1) at RES_W+4 bits, then truncated; it cannot overflow given the MAX_DIGITS bound.
  - Divide-by-10 is done with a constant-divisor lookup or reciprocal; exact for 0..99.
- Reset asserted mid-sequence (e.g. after F0) returns to S_MAKE with an empty buffer. The following byte is treated as a make code.

Decomposition:
- Package quiz_kb_pkg:
  - scan-code constants: SC_BREAK=F0, SC_EXT=E0, SC_ENTER=5A, SC_BKSP=66;
  - FSM state enum {S_MAKE, S_BREAK, S_EXT, S_EXT_BREAK};
  - MAX_DIGITS default.
- Sub-module kb_digit_decode (combinational):
  - input scan_code;
  - outputs is_digit and digit[3:0] for both main-row and keypad codes.

Test Plan:
1. Bytes 1E, F0 1E, 46, F0 46, 5A -> kb_result=29 and digit_count=2 after the last digit; submit high exactly one cycle after 5A; locked=1.
2. With locked=1, bytes 16, 5A -> kb_result stays 29, no submit. Then clear -> kb_result=0, locked=0, digit_count=0.
3. Bytes 26, 3E, 45 -> kb_result=38 (third digit ignored). Then 66 -> kb_result=3, digit_count=1. Then 66, 66 -> 0, count 0, no underflow.
4. Bytes 5A with empty buffer -> no submit. Then keypad 69, 72, then E0 5A -> kb_result=12, one submit pulse.
5. Bytes F0 then 16 -> 16 treated as a release, kb_result unchanged. Byte E0 75 (unknown extended code) -> ignored, FSM back in S_MAKE.
6. scan_valid with 16 in the same cycle as clear -> kb_result=0. Reset asserted between F0 and 16 -> outputs zero immediately, and the next 16 yields kb_result=1.

Source files
------------

// File: rtl/quiz_kb_pkg.sv
// rtl/quiz_kb_pkg.sv - shared scan-code constants and parser types for keyboard answer entry
package quiz_kb_pkg;

    localparam int MAX_DIGITS_DEFAULT = 2;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    typedef enum logic [1:0] {
        S_MAKE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } parse_state_t;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_DIGIT,
        ACT_BKSP,
        ACT_ENTER
    } key_action_t;

endpackage

// File: rtl/kb_digit_decode.sv
// rtl/kb_digit_decode.sv - maps main-row and keypad set-2 make codes to decimal digits
module kb_digit_decode (
    input  logic [7:0] scan_code,
    output logic       is_digit,
    output logic [3:0] digit
);

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (scan_code)
            8'h45, 8'h70: digit = 4'd0;
            8'h16, 8'h69: digit = 4'd1;
            8'h1E, 8'h72: digit = 4'd2;
            8'h26, 8'h7A: digit = 4'd3;
            8'h25, 8'h6B: digit = 4'd4;
            8'h2E, 8'h73: digit = 4'd5;
            8'h36, 8'h74: digit = 4'd6;
            8'h3D, 8'h6C: digit = 4'd7;
            8'h3E, 8'h75: digit = 4'd8;
            8'h46, 8'h7D: digit = 4'd9;
            default:      is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/answer_entry.sv
// rtl/answer_entry.sv - PS/2 scan-code parser that assembles a typed decimal answer
module answer_entry
    import quiz_kb_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEFAULT,
    parameter int RES_W      = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       scan_code,
    input  logic             scan_valid,
    input  logic             clear,
    output logic [RES_W-1:0] kb_result,
    output logic [1:0]       digit_count,
    output logic             submit,
    output logic             locked
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    parse_state_t     state_q;
    parse_state_t     state_d;
    key_action_t      action;
    logic             is_digit;
    logic [3:0]       digit;
    logic [RES_W+3:0] times_ten;
    logic [RES_W+7:0] recip_prod;
    logic [RES_W-1:0] div_ten;

    kb_digit_decode u_decode (
        .scan_code (scan_code),
        .is_digit  (is_digit),
        .digit     (digit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_MAKE;
        end else if (clear) begin
            state_q <= S_MAKE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prefix tracking runs even while locked so a later clear finds the stream aligned.
    always_comb begin
        state_d = state_q;
        if (scan_valid) begin
            case (state_q)
                S_MAKE: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = S_BREAK;
                    end else if (scan_code == SC_EXT) begin
                        state_d = S_EXT;
                    end
                end
                S_EXT: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = S_EXT_BREAK;
                    end else begin
                        state_d = S_MAKE;
                    end
                end
                default: state_d = S_MAKE;
            endcase
        end
    end

    always_comb begin
        action = ACT_NONE;
        if (scan_valid && !locked) begin
            case (state_q)
                S_MAKE: begin
                    if (is_digit) begin
                        action = ACT_DIGIT;
                    end else if (scan_code == SC_BKSP) begin
                        action = ACT_BKSP;
                    end else if (scan_code == SC_ENTER) begin
                        action = ACT_ENTER;
                    end
                end
                S_EXT: begin
                    if (scan_code == SC_ENTER) begin
                        action = ACT_ENTER;
                    end
                end
                default: action = ACT_NONE;
            endcase
        end
    end

    // x*10 as two shifts; x/10 as x*205 >> 11, exact for x below 1029.
    assign times_ten  = ({4'b0, kb_result} << 3) + ({4'b0, kb_result} << 1)
                      + {{RES_W{1'b0}}, digit};
    assign recip_prod = {8'b0, kb_result} * (RES_W+8)'(205);
    assign div_ten    = RES_W'(recip_prod >> 11);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kb_result   <= '0;
            digit_count <= 2'd0;
            submit      <= 1'b0;
            locked      <= 1'b0;
        end else begin
            submit <= 1'b0;
            if (clear) begin
                kb_result   <= '0;
                digit_count <= 2'd0;
                locked      <= 1'b0;
            end else begin
                case (action)
                    ACT_DIGIT: begin
                        if (digit_count < MAX_CNT) begin
                            kb_result   <= RES_W'(times_ten);
                            digit_count <= digit_count + 2'd1;
                        end
                    end
                    ACT_BKSP: begin
                        if (digit_count != 2'd0) begin
                            kb_result   <= div_ten;
                            digit_count <= digit_count - 2'd1;
                        end
                    end
                    ACT_ENTER: begin
                        if (digit_count != 2'd0) begin
                            submit <= 1'b1;
                            locked <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_answer_entry.sv
// tb/tb_answer_entry.sv - directed and randomized checks of answer_entry against a digit-list model
module tb_answer_entry;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] kb_result;
    logic [1:0] digit_count;
    logic       submit;
    logic       locked;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: typed digits as a list, pending prefix bytes as a list, and a lock flag.
    int         digs[$];
    logic [7:0] pfx[$];
    bit         m_lock = 1'b0;
    int         dmap[logic [7:0]];

    logic [7:0] main_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] kp_codes[10]   = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                   8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    answer_entry #(.MAX_DIGITS(2), .RES_W(7)) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .clear       (clear),
        .kb_result   (kb_result),
        .digit_count (digit_count),
        .submit      (submit),
        .locked      (locked)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_value();
        int v = 0;
        foreach (digs[i]) v = v * 10 + digs[i];
        return v;
    endfunction

    task automatic check_all(input string tag, input bit pulse);
        chk({tag, ".kb_result"}, 32'(kb_result), model_value());
        chk({tag, ".digit_count"}, 32'(digit_count), digs.size());
        chk({tag, ".submit"}, 32'(submit), 32'(pulse));
        chk({tag, ".locked"}, 32'(locked), 32'(m_lock));
    endtask

    task automatic apply_key(input logic [7:0] b, output bit pulse);
        pulse = 1'b0;
        if (m_lock) return;
        if (dmap.exists(b)) begin
            if (digs.size() < 2) digs.push_back(dmap[b]);
        end else if (b == 8'h66) begin
            if (digs.size() > 0) void'(digs.pop_back());
        end else if (b == 8'h5A) begin
            if (digs.size() > 0) begin
                pulse  = 1'b1;
                m_lock = 1'b1;
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit pulse);
        pulse = 1'b0;
        if (pfx.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
            else apply_key(b, pulse);
        end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
            if (b == 8'hF0) begin
                pfx.push_back(b);
            end else begin
                pfx.delete();
                if (b == 8'h5A) apply_key(b, pulse);
            end
        end else begin
            pfx.delete();
        end
    endtask

    task automatic model_empty();
        digs.delete();
        pfx.delete();
        m_lock = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic send(input logic [7:0] b, input bit clr, input string tag);
        bit pulse = 1'b0;
        scan_code  = b;
        scan_valid = 1'b1;
        clear      = clr;
        @(negedge clock);
        scan_valid = 1'b0;
        clear      = 1'b0;
        if (clr) model_empty();
        else model_byte(b, pulse);
        check_all(tag, pulse);
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        model_empty();
        check_all(tag, 1'b0);
    endtask

    task automatic idle(input string tag);
        @(negedge clock);
        check_all(tag, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        model_empty();
        check_all({tag, ".async"}, 1'b0);
        #1 reset = 1'b0;
        @(negedge clock);
        check_all({tag, ".after"}, 1'b0);
    endtask

    function automatic logic [7:0] pick_byte();
        int r = $urandom_range(0, 99);
        int d = $urandom_range(0, 9);
        if (r < 25) return main_codes[d];
        if (r < 45) return kp_codes[d];
        if (r < 57) return 8'hF0;
        if (r < 65) return 8'hE0;
        if (r < 75) return 8'h5A;
        if (r < 87) return 8'h66;
        return 8'($urandom);
    endfunction

    initial begin
        for (int i = 0; i < 10; i++) begin
            dmap[main_codes[i]] = i;
            dmap[kp_codes[i]]   = i;
        end

        repeat (2) @(negedge clock);
        check_all("reset_hold", 1'b0);
        reset = 1'b0;
        idle("reset_release");

        // Two digits with releases, then Enter
        send(8'h1E, 1'b0, "t1_d2");
        send(8'hF0, 1'b0, "t1_f0a");
        send(8'h1E, 1'b0, "t1_rel2");
        send(8'h46, 1'b0, "t1_d9");
        chk("t1_value29", 32'(kb_result), 29);
        chk("t1_count2", 32'(digit_count), 2);
        send(8'hF0, 1'b0, "t1_f0b");
        send(8'h46, 1'b0, "t1_rel9");
        send(8'h5A, 1'b0, "t1_enter");
        chk("t1_submit_hi", 32'(submit), 1);
        idle("t1_submit_drop");
        chk("t1_locked", 32'(locked), 1);

        // Locked: keystrokes ignored until clear
        send(8'h16, 1'b0, "t2_d1_locked");
        send(8'h5A, 1'b0, "t2_enter_locked");
        chk("t2_hold29", 32'(kb_result), 29);
        do_clear("t2_clear");
        chk("t2_unlocked", 32'(locked), 0);

        // Third digit ignored; backspace down past zero
        send(8'h26, 1'b0, "t3_d3");
        send(8'h3E, 1'b0, "t3_d8");
        send(8'h45, 1'b0, "t3_d0_full");
        chk("t3_value38", 32'(kb_result), 38);
        send(8'h66, 1'b0, "t3_bs1");
        chk("t3_value3", 32'(kb_result), 3);
        send(8'h66, 1'b0, "t3_bs2");
        send(8'h66, 1'b0, "t3_bs3_empty");
        chk("t3_count0", 32'(digit_count), 0);

        // Empty Enter ignored; keypad digits and extended Enter
        send(8'h5A, 1'b0, "t4_enter_empty");
        send(8'h69, 1'b0, "t4_kp1");
        send(8'h72, 1'b0, "t4_kp2");
        send(8'hE0, 1'b0, "t4_e0");
        send(8'h5A, 1'b0, "t4_kp_enter");
        chk("t4_value12", 32'(kb_result), 12);
        chk("t4_submit_hi", 32'(submit), 1);
        idle("t4_submit_drop");
        do_clear("t4_clear");

        // Release and unknown extended codes ignored
        send(8'hF0, 1'b0, "t5_f0");
        send(8'h16, 1'b0, "t5_rel1");
        send(8'hE0, 1'b0, "t5_e0");
        send(8'h75, 1'b0, "t5_ext_unknown");
        send(8'h16, 1'b0, "t5_d1_after");
        chk("t5_value1", 32'(kb_result), 1);
        send(8'h3D, 1'b0, "t5_leading");
        send(8'hE0, 1'b0, "t5_e0b");
        send(8'hF0, 1'b0, "t5_e0f0");
        send(8'h5A, 1'b0, "t5_ext_release_enter");

        // Clear beats a simultaneous byte; reset mid-prefix
        send(8'h16, 1'b1, "t6_clear_wins");
        chk("t6_value0", 32'(kb_result), 0);
        send(8'h26, 1'b0, "t6_d3");
        send(8'hF0, 1'b0, "t6_f0");
        do_reset("t6_reset");
        send(8'h16, 1'b0, "t6_d1_make");
        chk("t6_value1", 32'(kb_result), 1);

        // Leading zero keeps the count
        do_clear("t7_clear");
        send(8'h45, 1'b0, "t7_d0");
        send(8'h3D, 1'b0, "t7_d7");
        chk("t7_value7", 32'(kb_result), 7);
        chk("t7_count2", 32'(digit_count), 2);

        // Enter and clear together: clear wins, no submit
        send(8'h5A, 1'b1, "t8_enter_with_clear");

        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset("rnd_reset");
            end else if (r < 6) begin
                send(pick_byte(), 1'b1, "rnd_clear_byte");
            end else if (r < 8) begin
                do_clear("rnd_clear");
            end else if (r < 12) begin
                idle("rnd_idle");
            end else begin
                send(pick_byte(), 1'b0, "rnd_byte");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
